button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Front-end stage for the reaction-time game. It conditions the raw active-low push buttons (NEXT, PLAYER_A, PLAYER_B) before they reach the game FSM. Each channel gets a two-flop synchronizer, a consecutive-sample debouncer, a clean active-low level and one-cycle press/release pulses. A first-press arbiter records which player pressed first in an armed window, so the game FSM has a fair, glitch-free winner decision.

Parameters:
N_BTN, 3, number of button channels (bit 0 = NEXT, bit 1 = PLAYER_A, bit 2 = PLAYER_B)
DEBOUNCE_CYCLES, 16, consecutive synchronized samples required to accept a level change (legal range 2..2^CNT_W-1)
CNT_W, 5, width of each per-channel debounce counter
ID_W, 2, width of FIRST_ID; must satisfy 2^ID_W >= N_BTN

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
BTN_RAW  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to CLK
ARM  input  1  level; 1 opens the first-press capture window, 0 closes and clears it
BTN_CLEAN  output  N_BTN  debounced level, active-low, same polarity as BTN_RAW
PRESS  output  N_BTN  one-cycle pulse when BTN_CLEAN[i] falls 1->0
RELEASE  output  N_BTN  one-cycle pulse when BTN_CLEAN[i] rises 0->1
FIRST_VALID  output  1  1 once a press has been captured in the current armed window
FIRST_ID  output  ID_W  index of the captured channel; valid only while FIRST_VALID=1
MULTI  output  1  1 if more than one PRESS bit was set in the capture cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RESET=0, asynchronous) values:
  - Synchronizer flops = all 1.
  - BTN_CLEAN = all 1 (released).
  - Counters = 0.
  - PRESS, RELEASE = 0.
  - FIRST_VALID = 0, FIRST_ID = 0, MULTI = 0.
- Reset release is synchronous in effect: the first update happens on the first rising edge with RESET=1.
- Synchronizer: s1 <= BTN_RAW, s2 <= s1. Only s2 feeds downstream logic.
- Debouncer, per channel, evaluated on each rising edge:
  - If s2 == BTN_CLEAN: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: BTN_CLEAN <= s2 and counter <= 0.
  - Else: counter <= counter+1.
- Latency: if BTN_RAW[i] changes before edge k and holds, BTN_CLEAN[i] changes on edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges including the sampling edge.
- Glitch rejection: any return of s2 to the BTN_CLEAN value before the count completes resets the counter. No output change occurs and no pulse is emitted.
- PRESS[i] and RELEASE[i] are registered. They are high for exactly the one cycle after the edge on which BTN_CLEAN[i] changes, and never both high at once.
- Channels are fully independent; simultaneous changes on several channels are each handled normally.
- Arbiter states:
  - IDLE: ARM=0, FIRST_VALID=0.
  - ARMED: ARM=1, FIRST_VALID=0.
  - CAPTURED: FIRST_VALID=1.
- Arbiter transitions:
  - IDLE -> ARMED when ARM=1.
  - ARMED -> CAPTURED on the first edge where ARM=1 and any PRESS bit = 1. On that edge FIRST_ID <= lowest set PRESS index and MULTI <= (popcount(PRESS) > 1).
  - CAPTURED holds FIRST_ID and MULTI, ignoring further presses, while ARM=1.
  - Any state -> IDLE on the edge where ARM=0: FIRST_VALID <= 0 and MULTI <= 0. FIRST_ID keeps its value but is don't-care.
  - PRESS pulses while ARM=0 are discarded. A button already held when ARM rises does not capture; only a new falling edge of BTN_CLEAN does.
- Reset mid-debounce or mid-capture: immediately returns every output to its reset value. A button held through reset release produces a PRESS pulse after the full debounce latency.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan:
1. DEBOUNCE_CYCLES=4: reset, then BTN_RAW=3'b111 -> BTN_CLEAN=3'b111 and all pulses 0. Drive BTN_RAW[1]=0 before edge 10 -> BTN_CLEAN[1]=0 after edge 15, PRESS=3'b010 for one cycle only.
2. Bounce on bit 2: 0 for 2 cycles, 1 for 1 cycle, 0 for 3 cycles, then 1 -> BTN_CLEAN[2] stays 1, PRESS stays 0. Then hold 0 for 6 cycles -> exactly one PRESS[2] pulse.
3. ARM=1, then release-then-press on bit 2 settling 3 cycles before bit 1 -> FIRST_VALID=1, FIRST_ID=2, MULTI=0. The later PRESS[1] is ignored. ARM=0 -> FIRST_VALID=0 on the next edge.
4. ARM=1, with bits 1 and 2 falling on the same edge -> FIRST_ID=1, MULTI=1.
5. Bit 1 held low (BTN_CLEAN[1]=0) before ARM rises -> no capture. Release then re-press -> capture with FIRST_ID=1.
6. Assert RESET=0 asynchronously mid-count and mid-CAPTURED state -> BTN_CLEAN=3'b111 and FIRST_VALID=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/button_conditioner.sv
// Front-end conditioner for the reaction-time game buttons.
// Each active-low channel is synchronized, debounced and edge-detected.
// A first-press arbiter then records which channel pressed first while ARM is high.
//
// Arbiter states:
//   state    | meaning
//   IDLE     | ARM low, capture window closed, FIRST_VALID=0
//   ARMED    | ARM high, waiting for the first new press
//   CAPTURED | winner latched in FIRST_ID/MULTI, later presses ignored
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int ID_W            = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_BTN-1:0] BTN_RAW,
  input  logic             ARM,
  output logic [N_BTN-1:0] BTN_CLEAN,
  output logic [N_BTN-1:0] PRESS,
  output logic [N_BTN-1:0] RELEASE,
  output logic             FIRST_VALID,
  output logic [ID_W-1:0]  FIRST_ID,
  output logic             MULTI
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } arb_state_t;

  logic [N_BTN-1:0] sync_1;
  logic [N_BTN-1:0] sync_2;
  logic [N_BTN-1:0] clean_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             capture;
  logic [ID_W-1:0]  cap_id;
  logic             cap_multi;
  logic [ID_W-1:0]  first_id_q;
  logic             multi_q;

  // Two-flop synchronizer; idle level of the pins is released (1).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= BTN_RAW;
      sync_2 <= sync_1;
    end
  end

  // Per-channel debounce counter; the level is accepted after a full run of differing samples.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clean_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_2[i] == clean_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          clean_q[i]   <= sync_2[i];
          cnt_q[i]     <= '0;
          press_q[i]   <= ~sync_2[i];
          release_q[i] <= sync_2[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and capture decision; the lowest pressed index wins ties.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    cap_id    = '0;
    cap_multi = (press_q & (press_q - N_BTN'(1))) != '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_q[i]) cap_id = ID_W'(i);
    end
    if (!ARM) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = ARMED;
        ARMED: begin
          if (press_q != '0) begin
            state_d = CAPTURED;
            capture = 1'b1;
          end
        end
        CAPTURED: state_d = CAPTURED;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Winner registers; FIRST_ID is left stale when the window closes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      first_id_q <= '0;
      multi_q    <= 1'b0;
    end else if (!ARM) begin
      multi_q <= 1'b0;
    end else if (capture) begin
      first_id_q <= cap_id;
      multi_q    <= cap_multi;
    end
  end

  assign BTN_CLEAN   = clean_q;
  assign PRESS       = press_q;
  assign RELEASE     = release_q;
  assign FIRST_VALID = (state_q == CAPTURED);
  assign FIRST_ID    = first_id_q;
  assign MULTI       = multi_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a reference model pushes expected
// pulses and captures into queues, a monitor pops them when the DUT shows output.
module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] BTN_RAW = '1;
  logic         ARM = 1'b0;
  logic [N-1:0] BTN_CLEAN, PRESS, RELEASE;
  logic         FIRST_VALID, MULTI;
  logic [1:0]   FIRST_ID;

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(5), .ID_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .BTN_RAW(BTN_RAW), .ARM(ARM),
    .BTN_CLEAN(BTN_CLEAN), .PRESS(PRESS), .RELEASE(RELEASE),
    .FIRST_VALID(FIRST_VALID), .FIRST_ID(FIRST_ID), .MULTI(MULTI)
  );

  always #5 CLK = ~CLK;

  typedef struct { int c; logic [N-1:0] p; logic [N-1:0] r; } pev_t;
  typedef struct { int c; int id; int multi; } aev_t;

  pev_t pq[$];
  aev_t aq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: sampled history window of D synchronized samples per channel.
  logic [N-1:0] m_s1, m_s2, m_clean, m_press_prev;
  logic [N-1:0] win[$];
  bit           m_open, m_cap;

  always @(posedge CLK or negedge RESET) begin
    logic [N-1:0] seen, flip, prs, rel;
    bit all_diff;
    int id;
    if (!RESET) begin
      m_s1 = '1; m_s2 = '1; m_clean = '1; m_press_prev = '0;
      win.delete(); pq.delete(); aq.delete();
      m_open = 0; m_cap = 0;
    end else begin
      cyc++;
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = BTN_RAW;
      win.push_back(seen);
      if (win.size() > D) void'(win.pop_front());
      flip = '0;
      if (win.size() == D) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1;
          foreach (win[j]) if (win[j][i] == m_clean[i]) all_diff = 0;
          flip[i] = all_diff;
        end
      end
      if (ARM) begin
        if (m_open && !m_cap && m_press_prev != '0) begin
          id = 0;
          for (int i = N - 1; i >= 0; i--) if (m_press_prev[i]) id = i;
          m_cap = 1;
          aq.push_back('{c: cyc, id: id, multi: ($countones(m_press_prev) > 1) ? 1 : 0});
        end
        m_open = 1;
      end else begin
        m_open = 0;
        m_cap = 0;
      end
      prs = flip & m_clean;
      rel = flip & ~m_clean;
      m_clean = m_clean ^ flip;
      if ((prs | rel) != '0) pq.push_back('{c: cyc, p: prs, r: rel});
      m_press_prev = prs;
    end
  end

  // Monitor: compares levels every cycle and pops queues when the DUT emits events.
  logic fv_prev = 1'b0;
  always @(negedge CLK) begin
    pev_t pe;
    aev_t ae;
    if (RESET) begin
      chk("btn_clean", int'(BTN_CLEAN), int'(m_clean));
      chk("press_release_overlap", int'(PRESS & RELEASE), 0);
      if ((PRESS | RELEASE) != '0) begin
        if (pq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pulse press=%b release=%b expected=none cycle=%0d", PRESS, RELEASE, cyc);
        end else begin
          pe = pq.pop_front();
          chk("pulse_cycle", cyc, pe.c);
          chk("press", int'(PRESS), int'(pe.p));
          chk("release", int'(RELEASE), int'(pe.r));
        end
      end else if (pq.size() != 0 && pq[0].c <= cyc) begin
        pe = pq.pop_front();
        total++; bad++;
        $display("FAIL missed_pulse press=0 release=0 expected press=%b release=%b cycle=%0d", pe.p, pe.r, pe.c);
      end
      chk("first_valid", int'(FIRST_VALID), int'(m_cap));
      if (!FIRST_VALID) chk("multi_idle", int'(MULTI), 0);
      if (FIRST_VALID && !fv_prev) begin
        if (aq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_capture id=%0d expected=none cycle=%0d", FIRST_ID, cyc);
        end else begin
          ae = aq.pop_front();
          chk("capture_cycle", cyc, ae.c);
          chk("first_id", int'(FIRST_ID), ae.id);
          chk("multi", int'(MULTI), ae.multi);
        end
      end
    end
    fv_prev = FIRST_VALID;
  end

  task automatic hold(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_btn(int i, logic v);
    BTN_RAW[i] = v;
  endtask

  task automatic async_reset_check();
    @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    chk("rst_btn_clean", int'(BTN_CLEAN), 7);
    chk("rst_first_valid", int'(FIRST_VALID), 0);
    chk("rst_pulses", int'(PRESS | RELEASE), 0);
    chk("rst_multi", int'(MULTI), 0);
    chk("rst_first_id", int'(FIRST_ID), 0);
    hold(2);
    RESET = 1'b1;
  endtask

  initial begin
    #2 RESET = 1'b0;
    hold(3);
    chk("reset_clean", int'(BTN_CLEAN), 7);
    chk("reset_pulses", int'(PRESS | RELEASE), 0);
    chk("reset_first_valid", int'(FIRST_VALID), 0);
    RESET = 1'b1;
    hold(8);

    // Single press and release on PLAYER_A.
    set_btn(1, 0); hold(10);
    set_btn(1, 1); hold(10);

    // Bounce on PLAYER_B that never settles long enough, then a real press.
    set_btn(2, 0); hold(2);
    set_btn(2, 1); hold(1);
    set_btn(2, 0); hold(3);
    set_btn(2, 1); hold(8);
    set_btn(2, 0); hold(6);
    set_btn(2, 1); hold(10);

    // PLAYER_B settles three cycles before PLAYER_A.
    ARM = 1; hold(2);
    set_btn(2, 0); hold(3);
    set_btn(1, 0); hold(10);
    ARM = 0; hold(2);
    BTN_RAW = '1; hold(8);

    // Simultaneous press: lowest index wins and MULTI is flagged.
    ARM = 1; hold(2);
    BTN_RAW = 3'b001; hold(10);
    ARM = 0; hold(2);
    BTN_RAW = '1; hold(8);

    // Button already held when ARM rises does not capture.
    set_btn(1, 0); hold(10);
    ARM = 1; hold(5);
    set_btn(1, 1); hold(8);
    set_btn(1, 0); hold(8);
    ARM = 0; hold(2);
    BTN_RAW = '1; hold(8);

    // Asynchronous reset while captured and mid-count; PLAYER_B held through it.
    ARM = 1; hold(2);
    set_btn(2, 0); hold(8);
    set_btn(0, 0); hold(2);
    async_reset_check();
    hold(10);
    BTN_RAW = '1; ARM = 0; hold(10);

    // Random bouncing buttons and ARM toggling.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) BTN_RAW[i] = ~BTN_RAW[i];
      if ($urandom_range(0, 39) == 0) ARM = ~ARM;
      if ($urandom_range(0, 999) == 0) async_reset_check();
      else hold(1);
    end

    BTN_RAW = '1; hold(15);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("capture_queue_drained", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
